// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder: queued entry
// layout, access-size encodings, occupancy states and the stall LFSR.
package dsram_pkg;

    // Widest word index a 32-bit byte address can carry; the top module
    // keeps only the low ADDR_W bits, so higher address bits alias.
    localparam int IDX_MAX_W = 30;

    typedef struct packed {
        logic                 wr;
        logic [IDX_MAX_W-1:0] idx;
        logic [3:0]           wstrb;
        logic [31:0]          wdata;
    } dsram_entry_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } dsram_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FULL = 2'd2
    } dsram_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, left-shifting Fibonacci form
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dsram_req_fifo.sv
// In-order request queue for the data-SRAM responder. Synchronous FIFO of
// dsram_entry_t with push/pop, occupancy count and full/empty flags; the
// synchronous active-low reset flushes every pending entry.
module dsram_req_fifo
    import dsram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  dsram_entry_t           din,
    input  logic                   pop,
    output dsram_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dsram_entry_t     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage, no reset needed since occupancy gates its use
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/dsram_responder.sv
// Responder end of the Execute-stage data-SRAM interface. Queues up to
// DEPTH requests, services them in order against a 2^ADDR_W-word RAM after
// LAT cycles at the head, and answers each with a one-cycle data_ok.
// Optional build macro DSRAM_RAND_DELAY_EN adds LFSR-driven extra head
// latency (0-3 cycles) and random addr_ok back-pressure.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | queue empty
// ST_BUSY | 0 < count < DEPTH, requests still accepted
// ST_FULL | count == DEPTH, addr_ok held low
module dsram_responder
    import dsram_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4,
    parameter int LAT    = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(LAT + 4) + 1;

    dsram_state_e      state;
    dsram_state_e      state_nxt;
    dsram_entry_t      in_entry;
    dsram_entry_t      fifo_head;
    dsram_entry_t      head;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              acc;
    logic              head_valid;
    logic              fire;
    logic              stall;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_target;
    logic [ADDR_W-1:0] head_idx;
    logic [31:0]       mem [2**ADDR_W];
    logic              unused_bits;

    assign acc      = req && addr_ok;
    assign in_entry = '{wr: wr, idx: addr[31:2], wstrb: wstrb, wdata: wdata};

    // A request arriving at an empty queue is head in its own accept cycle,
    // which is what makes data_ok land exactly LAT cycles after acceptance.
    always_comb begin
        head       = fifo_empty ? in_entry : fifo_head;
        head_valid = !fifo_empty || acc;
    end

    assign head_idx  = head.idx[ADDR_W-1:0];
    assign fire      = head_valid && (wait_cnt == wait_target);
    assign fifo_pop  = fire && !fifo_empty;
    // An empty-queue request finished in its accept cycle never enters the FIFO
    assign fifo_push = acc && !(fifo_empty && fire);
    assign count_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    dsram_req_fifo #(
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .din   (in_entry),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef DSRAM_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic [1:0] extra_q;

    // Free-running stall source, restarted from a fixed seed on reset
    always_ff @(posedge clk) begin
        if (!rstn) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next(lfsr);
    end

    // Extra head delay is frozen while an entry is at the head
    always_ff @(posedge clk) begin
        if (!rstn)                    extra_q <= '0;
        else if (!head_valid || fire) extra_q <= lfsr[1:0];
    end

    assign stall       = lfsr[7];
    assign wait_target = WAIT_W'(LAT - 1) + WAIT_W'(extra_q);
`else
    assign stall       = 1'b0;
    assign wait_target = WAIT_W'(LAT - 1);
`endif

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next occupancy state follows the post-edge queue count
    always_comb begin
        state_nxt = ST_BUSY;
        if (count_nxt == '0)                  state_nxt = ST_IDLE;
        else if (count_nxt == CNT_W'(DEPTH))  state_nxt = ST_FULL;
    end

    // Acceptance depends only on registered state, never on a same-cycle pop
    always_comb begin
        addr_ok = (state != ST_FULL) && !stall;
    end

    // Head service timer: counts edges the current head has waited
    always_ff @(posedge clk) begin
        if (!rstn)           wait_cnt <= '0;
        else if (fire)       wait_cnt <= '0;
        else if (head_valid) wait_cnt <= wait_cnt + 1'b1;
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (rstn && fire && head.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (head.wstrb[i]) mem[head_idx][8*i +: 8] <= head.wdata[8*i +: 8];
            end
        end
    end

    // Registered response: one-cycle data_ok, read data or zero for writes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= fire;
            if (fire) rdata <= head.wr ? 32'h0 : mem[head_idx];
        end
    end

    assign unused_bits = ^{size, addr[1:0], head.idx[IDX_MAX_W-1:ADDR_W], fifo_full};

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: a LAT=1 instance for data path and
// byte-lane checks, and a DEPTH=4/LAT=4 instance for queueing, back-pressure
// and mid-operation reset.
module tb_dsram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rstn, a_req, a_wr, a_addr_ok, a_data_ok;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;

    logic        b_rstn, b_req, b_wr, b_addr_ok, b_data_ok;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    dsram_responder #(.ADDR_W(12), .DEPTH(4), .LAT(1)) u_dut_l1 (
        .clk(clk), .rstn(a_rstn), .req(a_req), .wr(a_wr), .size(a_size),
        .addr(a_addr), .wstrb(a_wstrb), .wdata(a_wdata),
        .addr_ok(a_addr_ok), .data_ok(a_data_ok), .rdata(a_rdata)
    );

    dsram_responder #(.ADDR_W(12), .DEPTH(4), .LAT(4)) u_dut_l4 (
        .clk(clk), .rstn(b_rstn), .req(b_req), .wr(b_wr), .size(b_size),
        .addr(b_addr), .wstrb(b_wstrb), .wdata(b_wdata),
        .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One LAT=1 transaction: accept in cycle T, response in T+1
    task automatic a_txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] exp, input string tag);
        @(negedge clk);
        check({tag, "_idle_dok"}, 32'(a_data_ok), 32'd0);
        a_req = 1'b1; a_wr = w; a_addr = a; a_wstrb = s; a_wdata = d; a_size = 2'd2;
        check({tag, "_aok"}, 32'(a_addr_ok), 32'd1);
        @(negedge clk);
        a_req = 1'b0;
        check({tag, "_dok"}, 32'(a_data_ok), 32'd1);
        check({tag, "_rdata"}, a_rdata, exp);
    endtask

    // One LAT=4 transaction on an empty queue, latency measured with a bound
    task automatic b_txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] exp, input string tag);
        int lat;
        @(negedge clk);
        b_req = 1'b1; b_wr = w; b_addr = a; b_wstrb = s; b_wdata = d; b_size = 2'd2;
        check({tag, "_aok"}, 32'(b_addr_ok), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            b_req = 1'b0;
            lat++;
        end while (!b_data_ok && lat < 20);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_rdata"}, b_rdata, exp);
    endtask

    initial begin
        int acc_n;
        logic exp_aok, exp_dok;

        a_rstn = 1'b0; a_req = 1'b0; a_wr = 1'b0; a_size = 2'd0;
        a_addr = '0; a_wstrb = '0; a_wdata = '0;
        b_rstn = 1'b0; b_req = 1'b0; b_wr = 1'b0; b_size = 2'd0;
        b_addr = '0; b_wstrb = '0; b_wdata = '0;

        repeat (3) @(negedge clk);
        a_rstn = 1'b1; b_rstn = 1'b1;
        check("rst_a_aok",   32'(a_addr_ok), 32'd1);
        check("rst_a_dok",   32'(a_data_ok), 32'd0);
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_b_aok",   32'(b_addr_ok), 32'd1);
        check("rst_b_dok",   32'(b_data_ok), 32'd0);

        // LAT=1 data path and byte lanes
        a_txn(1'b1, 32'h10,   4'hF,    32'hDEADBEEF, 32'h0,        "w_full");
        a_txn(1'b0, 32'h10,   4'h0,    32'h0,        32'hDEADBEEF, "r_full");
        a_txn(1'b1, 32'h12,   4'b0100, 32'h55555555, 32'h0,        "w_byte");
        a_txn(1'b0, 32'h10,   4'h0,    32'h0,        32'hDE55BEEF, "r_byte");
        a_txn(1'b1, 32'h10,   4'h0,    32'h12345678, 32'h0,        "w_nostrb");
        a_txn(1'b0, 32'h10,   4'hF,    32'h0,        32'hDE55BEEF, "r_nostrb");
        a_txn(1'b1, 32'h4010, 4'hF,    32'hCAFEF00D, 32'h0,        "w_alias");
        a_txn(1'b0, 32'h0010, 4'h0,    32'h0,        32'hCAFEF00D, "r_alias");
        a_txn(1'b1, 32'h12,   4'b1100, 32'hABCDABCD, 32'h0,        "w_half");
        a_txn(1'b0, 32'h10,   4'h0,    32'h0,        32'hABCDF00D, "r_half");

        // Back-to-back write then read of the same word
        @(negedge clk);
        check("pipe_idle_dok", 32'(a_data_ok), 32'd0);
        a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h40; a_wstrb = 4'hF; a_wdata = 32'h11223344;
        check("pipe_w_aok", 32'(a_addr_ok), 32'd1);
        @(negedge clk);
        check("pipe_w_dok", 32'(a_data_ok), 32'd1);
        check("pipe_w_rdata", a_rdata, 32'h0);
        a_wr = 1'b0; a_wstrb = 4'h0;
        check("pipe_r_aok", 32'(a_addr_ok), 32'd1);
        @(negedge clk);
        a_req = 1'b0;
        check("pipe_r_dok", 32'(a_data_ok), 32'd1);
        check("pipe_r_rdata", a_rdata, 32'h11223344);

        // LAT=4: preload five words
        for (int i = 0; i < 5; i++)
            b_txn(1'b1, 32'(i * 4), 4'hF, 32'hA0000000 + 32'(i), 32'h0, $sformatf("pre%0d", i));

        // LAT=4: req held 6 cycles with reads; responses at cycles 4,8,12,16,20
        acc_n = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            b_req = (k < 6); b_wr = 1'b0; b_wstrb = 4'h0; b_addr = 32'(acc_n * 4);
            exp_aok = !(k >= 5 && k <= 7);
            check($sformatf("burst_aok%0d", k), 32'(b_addr_ok), 32'(exp_aok));
            if (b_req && b_addr_ok) acc_n++;
            exp_dok = (k % 4 == 0) && (k >= 4) && (k <= 20);
            check($sformatf("burst_dok%0d", k), 32'(b_data_ok), 32'(exp_dok));
            if (exp_dok)
                check($sformatf("burst_rdata%0d", k), b_rdata, 32'hA0000000 + 32'(k / 4 - 1));
        end
        b_req = 1'b0;
        check("burst_accepts", 32'(acc_n), 32'd5);

        // Two outstanding reads dropped by a one-cycle reset
        @(negedge clk);
        b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h0;
        check("rst2_aok0", 32'(b_addr_ok), 32'd1);
        @(negedge clk);
        b_addr = 32'h4;
        check("rst2_aok1", 32'(b_addr_ok), 32'd1);
        @(negedge clk);
        b_req = 1'b0; b_rstn = 1'b0;
        @(negedge clk);
        b_rstn = 1'b1;
        check("rst2_first_aok", 32'(b_addr_ok), 32'd1);
        check("rst2_rdata", b_rdata, 32'h0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("rst2_nodok%0d", k), 32'(b_data_ok), 32'd0);
            @(negedge clk);
        end
        b_txn(1'b0, 32'h8, 4'h0, 32'h0, 32'hA0000002, "post_rst_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
